// File: rtl/ps2_key_event.sv
// PS/2 set-2 scan-code decoder: turns make/break byte sequences into one-cycle
// key pulses, held levels and a last-key index, with a stale-prefix timeout.
module ps2_key_event #(
  parameter int TIMEOUT_CYC = 20000,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_code_valid,
  input  logic [7:0] i_code,
  output logic [5:0] o_key_pulse,
  output logic [5:0] o_key_held,
  output logic [2:0] o_last_key
);

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [5:0]       pulse_reg, pulse_next;
  logic [5:0]       held_reg, held_next;
  logic [2:0]       last_reg, last_next;

  logic       ext_sel;
  logic [2:0] key_id;
  logic [5:0] key_oh;
  logic       make_ev, brk_ev;

  // Returns key index+1, or 0 when the code is unmapped in the selected table.
  function automatic logic [2:0] map_code(input logic ext, input logic [7:0] code);
    logic [2:0] id;
    id = 3'd0;
    if (ext) begin
      case (code)
        8'h74:   id = 3'd1;
        8'h5A:   id = 3'd2;
        8'h6B:   id = 3'd3;
        default: id = 3'd0;
      endcase
    end else begin
      case (code)
        8'h24:   id = 3'd1;
        8'h5A:   id = 3'd2;
        8'h15:   id = 3'd3;
        8'h29:   id = 3'd4;
        8'h3C:   id = 3'd5;
        8'h2D:   id = 3'd6;
        default: id = 3'd0;
      endcase
    end
    return id;
  endfunction

  assign ext_sel = (state_reg == S_EXT) || (state_reg == S_EXT_BRK);
  assign key_id  = map_code(ext_sel, i_code);

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_key_oh
      assign key_oh[gi] = (key_id == 3'(gi + 1));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pulse_next = 6'd0;
    held_next  = held_reg;
    last_next  = last_reg;
    make_ev    = 1'b0;
    brk_ev     = 1'b0;

    if (i_code_valid) begin
      // A byte always wins over a timeout landing in the same cycle.
      cnt_next = '0;
      case (state_reg)
        S_IDLE: begin
          if (i_code == BRK_CODE)      state_next = S_BRK;
          else if (i_code == EXT_CODE) state_next = S_EXT;
          else                         make_ev = 1'b1;
        end
        S_BRK: begin
          brk_ev     = 1'b1;
          state_next = S_IDLE;
        end
        S_EXT: begin
          if (i_code == BRK_CODE) begin
            state_next = S_EXT_BRK;
          end else begin
            make_ev    = 1'b1;
            state_next = S_IDLE;
          end
        end
        default: begin
          brk_ev     = 1'b1;
          state_next = S_IDLE;
        end
      endcase
    end else if (state_reg != S_IDLE) begin
      // Fires as the count of cycles since the prefix reaches TIMEOUT_CYC.
      if (cnt_reg == CNT_LAST) begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end

    if (make_ev && (key_id != 3'd0) && ((key_oh & held_reg) == 6'd0)) begin
      pulse_next = key_oh;
      held_next  = held_reg | key_oh;
      last_next  = key_id;
    end else if (brk_ev) begin
      held_next = held_reg & ~key_oh;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      pulse_reg <= 6'd0;
      held_reg  <= 6'd0;
      last_reg  <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pulse_reg <= pulse_next;
      held_reg  <= held_next;
      last_reg  <= last_next;
    end
  end

  assign o_key_pulse = pulse_reg;
  assign o_key_held  = held_reg;
  assign o_last_key  = last_reg;

endmodule

// File: tb/tb_ps2_key_event.sv
// Self-checking bench for ps2_key_event: directed vector table, timeout and
// reset corner sequences, then random byte streams against a prefix-queue model.
module tb_ps2_key_event;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] code;
  logic [5:0] pulse, held;
  logic [2:0] last;

  always #5 clk = ~clk;

  ps2_key_event #(.TIMEOUT_CYC(T)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_code_valid (valid),
    .i_code       (code),
    .o_key_pulse  (pulse),
    .o_key_held   (held),
    .o_last_key   (last)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending prefix bytes kept in a queue, expiry by cycle age.
  logic [5:0] m_pulse, m_held;
  logic [2:0] m_last;
  logic [7:0] pfx[$];
  int         now = 0;
  int         last_acc = 0;

  logic [7:0] plain_tab[6] = '{8'h24, 8'h5A, 8'h15, 8'h29, 8'h3C, 8'h2D};
  logic [7:0] ext_tab[3]   = '{8'h74, 8'h5A, 8'h6B};

  function automatic int key_of(input bit ext, input logic [7:0] c);
    if (ext) begin
      for (int k = 0; k < 3; k++) if (ext_tab[k] == c) return k + 1;
    end else begin
      for (int k = 0; k < 6; k++) if (plain_tab[k] == c) return k + 1;
    end
    return 0;
  endfunction

  task automatic m_make(input int k);
    if (k != 0 && !m_held[k-1]) begin
      m_held[k-1] = 1'b1;
      m_pulse     = 6'd1 << (k - 1);
      m_last      = 3'(k);
    end
  endtask

  task automatic m_break(input int k);
    if (k != 0) m_held[k-1] = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] c);
    if (pfx.size() > 0 && (now - last_acc) > T) pfx.delete();
    last_acc = now;
    if (pfx.size() == 0) begin
      if (c == 8'hF0 || c == 8'hE0) pfx.push_back(c);
      else m_make(key_of(1'b0, c));
    end else if (pfx[0] == 8'hF0) begin
      m_break(key_of(1'b0, c));
      pfx.delete();
    end else if (pfx.size() == 1) begin
      if (c == 8'hF0) begin
        pfx.push_back(c);
      end else begin
        m_make(key_of(1'b1, c));
        pfx.delete();
      end
    end else begin
      m_break(key_of(1'b1, c));
      pfx.delete();
    end
  endtask

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got pulse=%b held=%b last=%0d, want pulse=%b held=%b last=%0d",
               name, act[14:9], act[8:3], act[2:0], req[14:9], req[8:3], req[2:0]);
    end
  endtask

  // One clock: drive inputs, advance model, sample 1 time unit after the edge.
  task automatic step(input bit v, input logic [7:0] c, input bit r);
    rst   = r;
    valid = v;
    code  = c;
    now++;
    m_pulse = 6'd0;
    if (r) begin
      m_held = 6'd0;
      m_last = 3'd0;
      pfx.delete();
    end else if (v) begin
      model_byte(c);
    end
    @(posedge clk);
    #1;
    check("model", {pulse, held, last}, {m_pulse, m_held, m_last});
  endtask

  typedef struct {
    bit         v;
    logic [7:0] c;
    logic [5:0] p;
    logic [5:0] h;
    logic [2:0] l;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit v, input logic [7:0] c, input logic [5:0] p,
                     input logic [5:0] h, input logic [2:0] l);
    vec_t e;
    e.v = v; e.c = c; e.p = p; e.h = h; e.l = l;
    vt.push_back(e);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; code = 8'h00;
    m_pulse = 6'd0; m_held = 6'd0; m_last = 3'd0;

    // basic make/break
    add(1, 8'h24, 6'b000001, 6'b000001, 3'd1);
    add(0, 8'h00, 6'b000000, 6'b000001, 3'd1);
    add(1, 8'hF0, 6'b000000, 6'b000001, 3'd1);
    add(1, 8'h24, 6'b000000, 6'b000000, 3'd1);
    // typematic
    add(1, 8'h5A, 6'b000010, 6'b000010, 3'd2);
    add(1, 8'h5A, 6'b000000, 6'b000010, 3'd2);
    add(1, 8'h5A, 6'b000000, 6'b000010, 3'd2);
    add(1, 8'h5A, 6'b000000, 6'b000010, 3'd2);
    add(1, 8'hF0, 6'b000000, 6'b000010, 3'd2);
    add(1, 8'h5A, 6'b000000, 6'b000000, 3'd2);
    add(1, 8'h5A, 6'b000010, 6'b000010, 3'd2);
    add(1, 8'hF0, 6'b000000, 6'b000010, 3'd2);
    add(1, 8'h5A, 6'b000000, 6'b000000, 3'd2);
    // extended
    add(1, 8'hE0, 6'b000000, 6'b000000, 3'd2);
    add(1, 8'h6B, 6'b000100, 6'b000100, 3'd3);
    add(1, 8'hE0, 6'b000000, 6'b000100, 3'd3);
    add(1, 8'hF0, 6'b000000, 6'b000100, 3'd3);
    add(1, 8'h6B, 6'b000000, 6'b000000, 3'd3);
    add(1, 8'hE0, 6'b000000, 6'b000000, 3'd3);
    add(1, 8'h75, 6'b000000, 6'b000000, 3'd3);
    add(1, 8'h24, 6'b000001, 6'b000001, 3'd1);
    add(1, 8'hF0, 6'b000000, 6'b000001, 3'd1);
    add(1, 8'h24, 6'b000000, 6'b000000, 3'd1);
    // extended make, plain break share a held bit
    add(1, 8'hE0, 6'b000000, 6'b000000, 3'd1);
    add(1, 8'h74, 6'b000001, 6'b000001, 3'd1);
    add(1, 8'hF0, 6'b000000, 6'b000001, 3'd1);
    add(1, 8'h24, 6'b000000, 6'b000000, 3'd1);
    // interleaved replay/uno
    add(1, 8'h2D, 6'b100000, 6'b100000, 3'd6);
    add(1, 8'h3C, 6'b010000, 6'b110000, 3'd5);
    add(1, 8'hF0, 6'b000000, 6'b110000, 3'd5);
    add(1, 8'h2D, 6'b000000, 6'b010000, 3'd5);
    add(1, 8'h3C, 6'b000000, 6'b010000, 3'd5);
    add(1, 8'hF0, 6'b000000, 6'b010000, 3'd5);
    add(1, 8'h3C, 6'b000000, 6'b000000, 3'd5);
    // non-key bytes ignored
    add(1, 8'hAA, 6'b000000, 6'b000000, 3'd5);
    add(1, 8'hFA, 6'b000000, 6'b000000, 3'd5);
    add(1, 8'hE1, 6'b000000, 6'b000000, 3'd5);

    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    check("reset", {pulse, held, last}, 15'd0);
    step(0, 8'h00, 0);

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].v, vt[i].c, 0);
      check($sformatf("vec%0d", i), {pulse, held, last}, {vt[i].p, vt[i].h, vt[i].l});
    end

    // timeout: gap of T drops the F0 prefix, so 0x29 is a make
    step(1, 8'hF0, 0);
    repeat (T) step(0, 8'h00, 0);
    step(1, 8'h29, 0);
    check("timeout_make", {pulse, held, last}, {6'b001000, 6'b001000, 3'd4});
    // gap of T-1: prefix still live, 0x29 is a break
    step(1, 8'hF0, 0);
    repeat (T - 1) step(0, 8'h00, 0);
    step(1, 8'h29, 0);
    check("timeout_edge_break", {pulse, held, last}, {6'b000000, 6'b000000, 3'd4});

    // reset mid-sequence drops the E0 prefix
    step(1, 8'h3C, 0);
    step(1, 8'hE0, 0);
    step(0, 8'h00, 1);
    check("rst_mid", {pulse, held, last}, 15'd0);
    step(1, 8'hF0, 0);
    step(1, 8'h3C, 0);
    check("rst_then_break", {pulse, held, last}, 15'd0);
    step(1, 8'hE0, 0);
    step(0, 8'h00, 1);
    step(1, 8'h3C, 0);
    check("rst_prefix_lost", {pulse, held, last}, {6'b010000, 6'b010000, 3'd5});

    // random streams
    begin
      logic [7:0] pool[14] = '{8'hF0, 8'hE0, 8'h24, 8'h5A, 8'h15, 8'h29, 8'h3C,
                               8'h2D, 8'h74, 8'h6B, 8'h75, 8'hAA, 8'hE1, 8'hF0};
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 299) == 0) begin
          step(0, 8'h00, 1);
        end else if ($urandom_range(0, 49) == 0) begin
          repeat ($urandom_range(T - 2, T + 2)) step(0, 8'h00, 0);
        end else begin
          step($urandom_range(0, 3) != 0, pool[$urandom_range(0, 13)], 0);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
